// File: rtl/tank_level_ctrl.sv
`timescale 1ns/1ps
// tank_level_ctrl
// Samples the ultrasonic distance word at a fixed period, rejects readings
// outside the usable range, keeps a 4-sample moving average and drives the
// reservoir pump relay with hysteresis, minimum dwell and a run timeout.
module tank_level_ctrl #(
  parameter int unsigned SAMPLE_CYCLES     = 2500000,
  parameter int unsigned MIN_DIST          = 2,
  parameter int unsigned MAX_DIST          = 400,
  parameter int unsigned ON_DIST           = 120,
  parameter int unsigned OFF_DIST          = 30,
  parameter int unsigned MIN_TOGGLE_CYCLES = 25000000,
  parameter int unsigned MAX_ON_CYCLES     = 1500000000,
  parameter int unsigned INVALID_LIMIT     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] distance,
  input  logic        fault_clr,
  output logic        pump_on,
  output logic [15:0] level_avg,
  output logic        avg_valid,
  output logic        fault,
  output logic [1:0]  fault_code
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PUMP_OFF = 2'd1,
    ST_PUMP_ON  = 2'd2,
    ST_FAULT    = 2'd3
  } state_t;

  localparam int INV_W = (INVALID_LIMIT < 1) ? 1 : $clog2(INVALID_LIMIT + 1);

  localparam logic [31:0]      L_SAMPLE_LAST = 32'(SAMPLE_CYCLES - 1);
  localparam logic [31:0]      L_MIN_TOGGLE  = 32'(MIN_TOGGLE_CYCLES);
  localparam logic [31:0]      L_RUN_LAST    = 32'(MAX_ON_CYCLES - 1);
  localparam logic [15:0]      L_MIN_DIST    = 16'(MIN_DIST);
  localparam logic [15:0]      L_MAX_DIST    = 16'(MAX_DIST);
  localparam logic [15:0]      L_ON_DIST     = 16'(ON_DIST);
  localparam logic [15:0]      L_OFF_DIST    = 16'(OFF_DIST);
  localparam logic [INV_W-1:0] L_INV_LIMIT   = INV_W'(INVALID_LIMIT);
  localparam logic [INV_W-1:0] L_INV_ONE     = INV_W'(1);

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_SENSOR  = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT = 2'b10;

  state_t             r_state;
  state_t             w_stateNext;
  logic [1:0]         w_faultCodeNext;

  logic [31:0]        r_sampleCnt;
  logic [31:0]        r_dwellCnt;
  logic [31:0]        r_runCnt;
  logic [3:0][15:0]   r_win;
  logic [2:0]         r_fill;
  logic [INV_W-1:0]   r_invCnt;
  logic [15:0]        r_levelAvg;
  logic               r_avgValid;
  logic               r_pumpOn;
  logic [1:0]         r_faultCode;

  logic               w_tick;
  logic               w_sampleValid;
  logic               w_validTick;
  logic               w_invalidTick;
  logic [3:0][15:0]   w_winNext;
  logic [17:0]        w_sumNext;
  logic [2:0]         w_fillNext;
  logic               w_faultClear;
  logic               w_sensorFault;
  logic               w_timeout;
  logic               w_dwellDone;
  logic               w_stateChange;

  // The tick fires on the last count of each sample period; the counter is
  // parked at zero while disabled or faulted so sampling restarts cleanly.
  assign w_tick        = enable && (r_state != ST_FAULT) && (r_sampleCnt == L_SAMPLE_LAST);
  assign w_sampleValid = (distance != 16'd0) && (distance >= L_MIN_DIST) && (distance <= L_MAX_DIST);
  assign w_validTick   = w_tick && w_sampleValid;
  assign w_invalidTick = w_tick && !w_sampleValid;

  // Newest sample enters slot 0; the average is taken over the updated window
  // so level_avg is available the cycle right after the tick.
  assign w_winNext  = {r_win[2], r_win[1], r_win[0], distance};
  assign w_sumNext  = {2'b00, w_winNext[0]} + {2'b00, w_winNext[1]}
                    + {2'b00, w_winNext[2]} + {2'b00, w_winNext[3]};
  assign w_fillNext = (r_fill == 3'd4) ? 3'd4 : (r_fill + 3'd1);

  assign w_faultClear  = (r_state == ST_FAULT) && fault_clr;
  assign w_sensorFault = (r_invCnt >= L_INV_LIMIT);
  // Fires on the edge where the run count would reach MAX_ON_CYCLES, so the
  // pump stays on for exactly MAX_ON_CYCLES cycles before the fault.
  assign w_timeout     = (r_runCnt >= L_RUN_LAST);
  assign w_dwellDone   = (r_dwellCnt >= L_MIN_TOGGLE);
  assign w_stateChange = (w_stateNext != r_state);

  // Sample period counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sampleCnt <= 32'd0;
    end else if (!enable || (r_state == ST_FAULT)) begin
      r_sampleCnt <= 32'd0;
    end else if (r_sampleCnt == L_SAMPLE_LAST) begin
      r_sampleCnt <= 32'd0;
    end else begin
      r_sampleCnt <= r_sampleCnt + 32'd1;
    end
  end

  // Averaging window, fill count and registered average; wiped on fault exit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_win      <= '0;
      r_fill     <= 3'd0;
      r_levelAvg <= 16'd0;
      r_avgValid <= 1'b0;
    end else if (w_faultClear) begin
      r_win      <= '0;
      r_fill     <= 3'd0;
      r_levelAvg <= 16'd0;
      r_avgValid <= 1'b0;
    end else if (w_validTick) begin
      r_win      <= w_winNext;
      r_fill     <= w_fillNext;
      r_levelAvg <= w_sumNext[17:2];
      r_avgValid <= (w_fillNext == 3'd4);
    end
  end

  // Consecutive invalid sample counter; any valid sample restarts the run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_invCnt <= '0;
    end else if (w_faultClear || w_validTick) begin
      r_invCnt <= '0;
    end else if (w_invalidTick && (r_invCnt < L_INV_LIMIT)) begin
      r_invCnt <= r_invCnt + L_INV_ONE;
    end
  end

  // Next-state decision: disable beats faults, faults beat hysteresis, and
  // only fault_clr gets out of FAULT.
  always_comb begin
    w_stateNext     = r_state;
    w_faultCodeNext = r_faultCode;
    if (r_state == ST_FAULT) begin
      if (fault_clr) begin
        w_stateNext     = ST_IDLE;
        w_faultCodeNext = CODE_NONE;
      end
    end else if (!enable) begin
      w_stateNext = ST_IDLE;
    end else if (w_sensorFault) begin
      w_stateNext     = ST_FAULT;
      w_faultCodeNext = CODE_SENSOR;
    end else if ((r_state == ST_PUMP_ON) && w_timeout) begin
      w_stateNext     = ST_FAULT;
      w_faultCodeNext = CODE_TIMEOUT;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_avgValid) begin
            w_stateNext = ST_PUMP_OFF;
          end
        end
        ST_PUMP_OFF: begin
          if ((r_levelAvg >= L_ON_DIST) && w_dwellDone) begin
            w_stateNext = ST_PUMP_ON;
          end
        end
        ST_PUMP_ON: begin
          if ((r_levelAvg <= L_OFF_DIST) && w_dwellDone) begin
            w_stateNext = ST_PUMP_OFF;
          end
        end
        default: begin
          w_stateNext = r_state;
        end
      endcase
    end
  end

  // State register with the relay command and fault code registered alongside.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_pumpOn    <= 1'b0;
      r_faultCode <= CODE_NONE;
    end else begin
      r_state     <= w_stateNext;
      r_pumpOn    <= (w_stateNext == ST_PUMP_ON);
      r_faultCode <= w_faultCodeNext;
    end
  end

  // Dwell counter: restarts on every state change, except that arriving in
  // PUMP_OFF from IDLE starts already satisfied so the first switch-on is
  // immediate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dwellCnt <= 32'd0;
    end else if (w_stateChange) begin
      if ((r_state == ST_IDLE) && (w_stateNext == ST_PUMP_OFF)) begin
        r_dwellCnt <= L_MIN_TOGGLE;
      end else begin
        r_dwellCnt <= 32'd0;
      end
    end else if (enable && (r_dwellCnt < L_MIN_TOGGLE)) begin
      r_dwellCnt <= r_dwellCnt + 32'd1;
    end
  end

  // Continuous run counter, live only while staying in PUMP_ON.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_runCnt <= 32'd0;
    end else if ((r_state != ST_PUMP_ON) || (w_stateNext != ST_PUMP_ON)) begin
      r_runCnt <= 32'd0;
    end else begin
      r_runCnt <= r_runCnt + 32'd1;
    end
  end

  assign pump_on    = r_pumpOn;
  assign level_avg  = r_levelAvg;
  assign avg_valid  = r_avgValid;
  assign fault      = (r_state == ST_FAULT);
  assign fault_code = r_faultCode;

endmodule

// File: tb/tb_tank_level_ctrl.sv
`timescale 1ns/1ps
// tb_tank_level_ctrl
// Directed bench for the reservoir pump controller with shortened timing
// parameters. Each applied sample pushes its expected average into a
// scoreboard queue that is popped once the DUT has registered the tick.
module tb_tank_level_ctrl;

  localparam int unsigned SAMPLE_CYCLES = 10;
  localparam int unsigned MIN_TOGGLE    = 50;
  localparam int unsigned MAX_ON        = 2000;
  localparam int unsigned INV_LIMIT     = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] distance;
  logic        fault_clr;
  logic        pump_on;
  logic [15:0] level_avg;
  logic        avg_valid;
  logic        fault;
  logic [1:0]  fault_code;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int riseCyc = -1;
  int fallCyc = -1;
  logic prevPump = 1'b0;
  int tickCyc;
  int onCyc;

  int modelWin[4];
  int modelFill;
  int expQ[$];

  tank_level_ctrl #(
    .SAMPLE_CYCLES(SAMPLE_CYCLES),
    .MIN_TOGGLE_CYCLES(MIN_TOGGLE),
    .MAX_ON_CYCLES(MAX_ON),
    .INVALID_LIMIT(INV_LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .distance(distance),
    .fault_clr(fault_clr),
    .pump_on(pump_on),
    .level_avg(level_avg),
    .avg_valid(avg_valid),
    .fault(fault),
    .fault_code(fault_code)
  );

  // 100 MHz bench clock; only the cycle count matters here.
  always #5 clk = ~clk;

  // Hard stop in case a wait never resolves.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and note pump_on edges by cycle number.
  task automatic stepCycle();
    @(negedge clk);
    cyc++;
    if (pump_on === 1'b1 && prevPump === 1'b0) riseCyc = cyc;
    if (pump_on === 1'b0 && prevPump === 1'b1) fallCyc = cyc;
    prevPump = pump_on;
  endtask

  task automatic modelClear();
    for (int i = 0; i < 4; i++) modelWin[i] = 0;
    modelFill = 0;
  endtask

  // Holds one distance for a full sample period (the tick lands on its last
  // cycle) and records the average the window should then show.
  task automatic applyStimulus(input int d);
    int sum;
    distance = 16'(d);
    if (d >= 2 && d <= 400) begin
      modelWin[3] = modelWin[2];
      modelWin[2] = modelWin[1];
      modelWin[1] = modelWin[0];
      modelWin[0] = d;
      if (modelFill < 4) modelFill++;
    end
    sum = modelWin[0] + modelWin[1] + modelWin[2] + modelWin[3];
    expQ.push_back(sum >> 2);
    repeat (SAMPLE_CYCLES) stepCycle();
  endtask

  task automatic checkScoreboard(input string tag);
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      checkOutput(tag, 32'(level_avg), expQ.pop_front());
    end
  endtask

  initial begin
    rst = 1'b0;
    enable = 1'b0;
    distance = 16'd0;
    fault_clr = 1'b0;
    modelClear();

    // Reset state.
    #12;
    checkOutput("rst_pump", 32'(pump_on), 0);
    checkOutput("rst_avg", 32'(level_avg), 0);
    checkOutput("rst_valid", 32'(avg_valid), 0);
    checkOutput("rst_fault", 32'(fault), 0);
    checkOutput("rst_code", 32'(fault_code), 0);
    @(negedge clk);
    rst = 1'b1;
    stepCycle();
    stepCycle();

    // Averaging and first turn-on with 200 cm held.
    $display("[TB] averaging and turn-on");
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(200);
      checkScoreboard("fill_avg");
      checkOutput("fill_valid", 32'(avg_valid), (i == 3) ? 1 : 0);
    end
    checkOutput("pump_off_at_valid", 32'(pump_on), 0);
    tickCyc = cyc;
    applyStimulus(200);
    checkScoreboard("on_avg");
    checkOutput("rise_latency", 32'(riseCyc - tickCyc), 2);
    onCyc = riseCyc;

    // Level drops to 20: full window is reached before the dwell expires,
    // so release waits for dwell >= MIN_TOGGLE (51st cycle in PUMP_ON).
    $display("[TB] hysteresis and dwell");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(20);
      checkScoreboard("drain_avg");
    end
    checkOutput("dwell_hold", 32'(pump_on), 1);
    applyStimulus(20);
    checkScoreboard("drain_avg2");
    checkOutput("pump_released", 32'(pump_on), 0);
    checkOutput("dwell_length", 32'(fallCyc - onCyc), MIN_TOGGLE + 1);

    // Inside the band while off: 35, 50, 65, 80.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(80);
      checkScoreboard("band_off_avg");
      checkOutput("band_off_pump", 32'(pump_on), 0);
    end
    applyStimulus(200);
    checkScoreboard("rise_avg110");
    checkOutput("below_on_pump", 32'(pump_on), 0);
    applyStimulus(200);
    checkScoreboard("rise_avg140");
    tickCyc = cyc;

    // Inside the band while on: 140, 140, 110, 80.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(80);
      checkScoreboard("band_on_avg");
      checkOutput("band_on_pump", 32'(pump_on), 1);
    end
    checkOutput("off_to_on_latency", 32'(riseCyc - tickCyc), 1);

    // Truncation and rejection of out-of-range readings.
    $display("[TB] truncation and rejection");
    applyStimulus(101);
    checkScoreboard("trunc_avg");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(102);
      checkScoreboard("trunc_avg");
    end
    checkOutput("trunc_value", 32'(level_avg), 101);
    applyStimulus(0);
    checkScoreboard("reject_zero");
    applyStimulus(1);
    checkScoreboard("reject_one");
    checkOutput("reject_keep", 32'(level_avg), 101);
    applyStimulus(102);
    checkScoreboard("valid_again");
    applyStimulus(401);
    checkScoreboard("reject_401");
    checkOutput("no_fault_yet", 32'(fault), 0);
    applyStimulus(102);
    checkScoreboard("valid_again2");

    // Sensor fault after three consecutive 500 cm readings.
    $display("[TB] sensor fault");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(500);
      checkScoreboard("invalid_avg");
    end
    checkOutput("sensor_fault_pending", 32'(fault), 0);
    stepCycle();
    checkOutput("sensor_fault", 32'(fault), 1);
    checkOutput("sensor_code", 32'(fault_code), 1);
    checkOutput("sensor_pump", 32'(pump_on), 0);
    enable = 1'b0;
    repeat (3) stepCycle();
    checkOutput("fault_holds_disabled", 32'(fault), 1);
    checkOutput("code_holds_disabled", 32'(fault_code), 1);
    enable = 1'b1;
    stepCycle();
    fault_clr = 1'b1;
    stepCycle();
    fault_clr = 1'b0;
    modelClear();
    checkOutput("clr_fault", 32'(fault), 0);
    checkOutput("clr_code", 32'(fault_code), 0);
    checkOutput("clr_valid", 32'(avg_valid), 0);
    checkOutput("clr_avg", 32'(level_avg), 0);

    // Run timeout with 200 cm held.
    $display("[TB] run timeout");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(200);
      checkScoreboard("refill_avg");
    end
    checkOutput("refill_valid", 32'(avg_valid), 1);
    for (int k = 0; k < 210 && fault !== 1'b1; k++) begin
      applyStimulus(200);
      checkScoreboard("run_avg");
    end
    checkOutput("timeout_fault", 32'(fault), 1);
    checkOutput("timeout_code", 32'(fault_code), 2);
    checkOutput("timeout_pump", 32'(pump_on), 0);
    checkOutput("run_length", 32'(fallCyc - riseCyc), MAX_ON);
    fault_clr = 1'b1;
    stepCycle();
    fault_clr = 1'b0;
    modelClear();
    checkOutput("clr2_fault", 32'(fault), 0);

    // fault_clr outside FAULT, then disable while pumping.
    $display("[TB] enable and fault_clr while pumping");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(200);
      checkScoreboard("restart_avg");
    end
    checkOutput("restart_pump", 32'(pump_on), 1);
    fault_clr = 1'b1;
    stepCycle();
    fault_clr = 1'b0;
    stepCycle();
    checkOutput("stray_clr_pump", 32'(pump_on), 1);
    checkOutput("stray_clr_fault", 32'(fault), 0);
    enable = 1'b0;
    stepCycle();
    checkOutput("disable_pump", 32'(pump_on), 0);
    checkOutput("disable_keep_valid", 32'(avg_valid), 1);
    checkOutput("disable_keep_avg", 32'(level_avg), 200);
    enable = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("reenable_pump", 32'(pump_on), 1);

    // Asynchronous reset in the middle of a cycle while pumping.
    $display("[TB] async reset mid-cycle");
    #2;
    rst = 1'b0;
    #1;
    checkOutput("arst_pump", 32'(pump_on), 0);
    checkOutput("arst_valid", 32'(avg_valid), 0);
    checkOutput("arst_fault", 32'(fault), 0);
    checkOutput("arst_avg", 32'(level_avg), 0);
    checkOutput("arst_code", 32'(fault_code), 0);
    #20;
    rst = 1'b1;
    #20;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
